// File: rtl/rs232_rx_ctrl_if.sv
// Byte stream between the serial receiver, the receive FIFO and its consumer.
// The master side is the environment (receiver strobe plus consumer ready); the slave side is the FIFO.
interface rs232_rx_ctrl_if;
    logic       rx_attention;
    logic [7:0] rx_data;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_ready;

    modport master (
        output rx_attention,
        output rx_data,
        output rd_ready,
        input  rd_valid,
        input  rd_data
    );

    modport slave (
        input  rx_attention,
        input  rx_data,
        input  rd_ready,
        output rd_valid,
        output rd_data
    );
endinterface

// File: rtl/rs232_rx_ctrl.sv
// Show-ahead receive FIFO for an RS-232 receiver, with overrun tracking.
// Optional RTS hysteresis flow control is compiled in by defining RS232_RX_CTRL_FLOWCTL_EN.
module rs232_rx_ctrl #(
    parameter int DEPTH_LOG2 = 4,
    parameter int HIGH_WATER = 12,
    parameter int LOW_WATER  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    rs232_rx_ctrl_if.slave        bus,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overrun,
    output logic [7:0]            drop_count,
    input  logic                  clear_overrun
`ifdef RS232_RX_CTRL_FLOWCTL_EN
    ,
    output logic                  rts_n
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [DEPTH_LOG2:0]   lvl_t;

    localparam lvl_t FULL_LVL = lvl_t'(DEPTH);

    if ((HIGH_WATER > DEPTH) || (LOW_WATER >= HIGH_WATER) || (LOW_WATER < 0)) begin : g_bad_watermarks
        $error("rs232_rx_ctrl: watermarks must satisfy 0 <= LOW_WATER < HIGH_WATER <= depth");
    end

    logic [7:0] r_mem [DEPTH];
    ptr_t       r_wr_ptr;
    ptr_t       r_rd_ptr;
    lvl_t       r_level;
    logic       r_rd_valid;
    logic [7:0] r_rd_data;
    logic       r_overrun;
    logic [7:0] r_drop_count;

    logic       w_full;
    logic       w_pop;
    logic       w_push;
    logic       w_drop;
    ptr_t       w_rd_ptr_next;
    ptr_t       w_wr_ptr_next;
    lvl_t       w_level_next;
    logic [7:0] w_head_next;

    // Full/empty come from the occupancy counter; pointers alone are ambiguous when equal.
    always_comb begin
        w_full        = (r_level == FULL_LVL);
        w_pop         = r_rd_valid & bus.rd_ready;
        w_push        = bus.rx_attention & (~w_full | w_pop);
        w_drop        = bus.rx_attention & ~w_push;
        w_rd_ptr_next = r_rd_ptr + ptr_t'(w_pop);
        w_wr_ptr_next = r_wr_ptr + ptr_t'(w_push);
        w_level_next  = r_level + lvl_t'(w_push) - lvl_t'(w_pop);
        // A byte written into the slot that becomes the head must bypass the array read.
        if (w_push && (r_wr_ptr == w_rd_ptr_next)) begin
            w_head_next = bus.rx_data;
        end else begin
            w_head_next = r_mem[w_rd_ptr_next];
        end
    end

    always_ff @(posedge clock) begin
        if (w_push && !reset) begin
            r_mem[r_wr_ptr] <= bus.rx_data;
        end
        r_rd_data <= w_head_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_rd_valid   <= 1'b0;
            r_overrun    <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_next;
            r_rd_ptr   <= w_rd_ptr_next;
            r_level    <= w_level_next;
            r_rd_valid <= (w_level_next != '0);
            // A drop wins over a coincident clear, restarting the count at one.
            if (w_drop) begin
                r_overrun <= 1'b1;
                if (clear_overrun) begin
                    r_drop_count <= 8'd1;
                end else if (r_drop_count != 8'hFF) begin
                    r_drop_count <= r_drop_count + 8'd1;
                end
            end else if (clear_overrun) begin
                r_overrun    <= 1'b0;
                r_drop_count <= '0;
            end
        end
    end

    assign bus.rd_valid = r_rd_valid;
    assign bus.rd_data  = r_rd_data;
    assign level        = r_level;
    assign overrun      = r_overrun;
    assign drop_count   = r_drop_count;

`ifdef RS232_RX_CTRL_FLOWCTL_EN
    localparam lvl_t HIGH_LVL = lvl_t'(HIGH_WATER);
    localparam lvl_t LOW_LVL  = lvl_t'(LOW_WATER);

    logic r_rts_n;

    // Hysteresis on the post-update occupancy so RTS moves in the same cycle as level.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rts_n <= 1'b0;
        end else if (w_level_next >= HIGH_LVL) begin
            r_rts_n <= 1'b1;
        end else if (w_level_next <= LOW_LVL) begin
            r_rts_n <= 1'b0;
        end
    end

    assign rts_n = r_rts_n;
`endif

endmodule

// File: tb/tb_rs232_rx_ctrl.sv
// Self-checking bench for rs232_rx_ctrl: directed table, corner sequences and a
// randomized run against a queue-based reference model.
module tb_rs232_rx_ctrl;
    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 16;
    localparam int HIGH_WATER = 12;
    localparam int LOW_WATER  = 4;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                clear_overrun = 1'b0;
    logic [DEPTH_LOG2:0] level;
    logic                overrun;
    logic [7:0]          drop_count;
`ifdef RS232_RX_CTRL_FLOWCTL_EN
    logic                rts_n;
`endif

    rs232_rx_ctrl_if bus();

    always #5 clock = ~clock;

    rs232_rx_ctrl #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .HIGH_WATER (HIGH_WATER),
        .LOW_WATER  (LOW_WATER)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .bus           (bus.slave),
        .level         (level),
        .overrun       (overrun),
        .drop_count    (drop_count),
        .clear_overrun (clear_overrun)
`ifdef RS232_RX_CTRL_FLOWCTL_EN
        ,
        .rts_n         (rts_n)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: the FIFO is a plain queue, flags are plain integers.
    logic [7:0] m_q[$];
    bit         m_ov  = 1'b0;
    int         m_dc  = 0;
    bit         m_rts = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input bit rst, input bit att, input logic [7:0] d,
                                input bit rdy, input bit clr);
        bit pop;
        bit ok;
        if (rst) begin
            m_q.delete();
            m_ov  = 1'b0;
            m_dc  = 0;
            m_rts = 1'b0;
        end else begin
            pop = (m_q.size() > 0) && rdy;
            ok  = att && ((m_q.size() < DEPTH) || pop);
            if (pop) void'(m_q.pop_front());
            if (ok) m_q.push_back(d);
            if (att && !ok) begin
                m_ov = 1'b1;
                m_dc = clr ? 1 : ((m_dc < 255) ? m_dc + 1 : 255);
            end else if (clr) begin
                m_ov = 1'b0;
                m_dc = 0;
            end
            if (m_q.size() >= HIGH_WATER) m_rts = 1'b1;
            else if (m_q.size() <= LOW_WATER) m_rts = 1'b0;
        end
    endtask

    task automatic model_check();
        chk("model_level", 32'(level), 32'(m_q.size()));
        chk("model_valid", 32'(bus.rd_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) chk("model_data", 32'(bus.rd_data), 32'(m_q[0]));
        chk("model_overrun", 32'(overrun), 32'(m_ov));
        chk("model_drop_count", 32'(drop_count), 32'(m_dc));
`ifdef RS232_RX_CTRL_FLOWCTL_EN
        chk("model_rts_n", 32'(rts_n), 32'(m_rts));
`endif
    endtask

    // One clock: drive, let the edge happen, advance the model, compare 1 time unit later.
    task automatic step(input bit rst, input bit att, input logic [7:0] d,
                        input bit rdy, input bit clr);
        reset            = rst;
        bus.rx_attention = att;
        bus.rx_data      = d;
        bus.rd_ready     = rdy;
        clear_overrun    = clr;
        @(posedge clock);
        model_update(rst, att, d, rdy, clr);
        #1;
        model_check();
    endtask

    task automatic fill(input int n, input int base);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 8'(base + i), 1'b0, 1'b0);
    endtask

    typedef struct {
        bit         rst;
        bit         att;
        logic [7:0] data;
        bit         rdy;
        bit         clr;
        int         lvl;
        bit         vld;
        logic [7:0] dout;
        bit         ov;
        int         dc;
    } vec_t;

    vec_t vecs[9];

    initial begin
        bus.rx_attention = 1'b0;
        bus.rx_data      = 8'h00;
        bus.rd_ready     = 1'b0;

        vecs[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b0, 0};
        vecs[1] = '{1'b0, 1'b1, 8'h41, 1'b0, 1'b0, 1, 1'b1, 8'h41, 1'b0, 0};
        vecs[2] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0, 0};
        vecs[3] = '{1'b0, 1'b1, 8'h10, 1'b0, 1'b0, 1, 1'b1, 8'h10, 1'b0, 0};
        vecs[4] = '{1'b0, 1'b1, 8'h20, 1'b1, 1'b0, 1, 1'b1, 8'h20, 1'b0, 0};
        vecs[5] = '{1'b0, 1'b1, 8'h30, 1'b0, 1'b0, 2, 1'b1, 8'h20, 1'b0, 0};
        vecs[6] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2, 1'b1, 8'h20, 1'b0, 0};
        vecs[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b1, 8'h30, 1'b0, 0};
        vecs[8] = '{1'b1, 1'b1, 8'h77, 1'b1, 1'b1, 0, 1'b0, 8'h00, 1'b0, 0};

        for (int i = 0; i < 9; i++) begin
            step(vecs[i].rst, vecs[i].att, vecs[i].data, vecs[i].rdy, vecs[i].clr);
            chk("vec_level", 32'(level), 32'(vecs[i].lvl));
            chk("vec_valid", 32'(bus.rd_valid), 32'(vecs[i].vld));
            if (vecs[i].vld) chk("vec_data", 32'(bus.rd_data), 32'(vecs[i].dout));
            chk("vec_overrun", 32'(overrun), 32'(vecs[i].ov));
            chk("vec_drop_count", 32'(drop_count), 32'(vecs[i].dc));
            $display("vec %0d: rst=%0b att=%0b data=%02h rdy=%0b clr=%0b -> level=%0d valid=%0b",
                     i, vecs[i].rst, vecs[i].att, vecs[i].data, vecs[i].rdy, vecs[i].clr,
                     level, bus.rd_valid);
        end

        // Fill to full, overflow once, then drain in order.
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        fill(16, 0);
        chk("full_level", 32'(level), 32'd16);
        chk("full_overrun", 32'(overrun), 32'd0);
        step(1'b0, 1'b1, 8'hAA, 1'b0, 1'b0);
        chk("ovf_overrun", 32'(overrun), 32'd1);
        chk("ovf_drop_count", 32'(drop_count), 32'd1);
        chk("ovf_level", 32'(level), 32'd16);
        for (int i = 0; i < 16; i++) begin
            chk("drain_data", 32'(bus.rd_data), 32'(i));
            step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("drain_level", 32'(level), 32'd0);
        chk("drain_valid", 32'(bus.rd_valid), 32'd0);
        $display("seq overflow: drop_count=%0d level=%0d", drop_count, level);

        // Push and pop together at full: accepted, no overrun.
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        fill(16, 0);
        step(1'b0, 1'b1, 8'h55, 1'b1, 1'b0);
        chk("fullpp_level", 32'(level), 32'd16);
        chk("fullpp_overrun", 32'(overrun), 32'd0);
        chk("fullpp_head", 32'(bus.rd_data), 32'h01);
        for (int i = 1; i < 16; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("fullpp_last", 32'(bus.rd_data), 32'h55);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("fullpp_empty", 32'(bus.rd_valid), 32'd0);
        $display("seq full push+pop: last byte read 0x55, level=%0d", level);

        // Saturating drop counter and clear/drop collision.
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        fill(16, 8'h80);
        for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 8'($urandom), 1'b0, 1'b0);
        chk("sat_drop_count", 32'(drop_count), 32'd255);
        chk("sat_overrun", 32'(overrun), 32'd1);
        chk("sat_level", 32'(level), 32'd16);
        step(1'b0, 1'b1, 8'h33, 1'b0, 1'b1);
        chk("clrdrop_overrun", 32'(overrun), 32'd1);
        chk("clrdrop_drop_count", 32'(drop_count), 32'd1);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr_overrun", 32'(overrun), 32'd0);
        chk("clr_drop_count", 32'(drop_count), 32'd0);
        chk("clr_head", 32'(bus.rd_data), 32'h80);
        $display("seq saturation/clear: overrun=%0b drop_count=%0d", overrun, drop_count);

        // Mid-stream reset with every other input active.
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        fill(7, 8'h20);
        chk("pre_rst_level", 32'(level), 32'd7);
        step(1'b1, 1'b1, 8'h99, 1'b1, 1'b1);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_drop_count", 32'(drop_count), 32'd0);
`ifdef RS232_RX_CTRL_FLOWCTL_EN
        chk("rst_rts_n", 32'(rts_n), 32'd0);
`endif
        $display("seq reset at level 7: level=%0d valid=%0b", level, bus.rd_valid);

`ifdef RS232_RX_CTRL_FLOWCTL_EN
        // RTS hysteresis between the watermarks.
        fill(11, 0);
        chk("rts_at11", 32'(rts_n), 32'd0);
        fill(1, 11);
        chk("rts_at12", 32'(rts_n), 32'd1);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("rts_lvl5", 32'(level), 32'd5);
        chk("rts_at5", 32'(rts_n), 32'd1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("rts_at4", 32'(rts_n), 32'd0);
        $display("seq rts hysteresis: rts_n=%0b level=%0d", rts_n, level);
`endif

        // Randomized traffic, alternating between filling and draining bias.
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int c = 0; c < 3000; c++) begin
            int rdy_pct;
            rdy_pct = (((c / 400) % 2) == 0) ? 25 : 85;
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 99) < 60,
                 8'($urandom),
                 $urandom_range(0, 99) < rdy_pct,
                 $urandom_range(0, 99) < 3);
        end
        $display("random run: 3000 cycles, final level=%0d drop_count=%0d", level, drop_count);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
